// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding and default widths for the count sequencer
package count_seq_pkg;
    localparam int WIDTH_D = 4;
    localparam int REP_W_D = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/up_count_clr.sv
// up_count_clr: up-counter with synchronous clear taking priority over enable
module up_count_clr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk)
        count <= clr ? '0 : en ? count + 1'b1 : count;
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: runs the up-counter through repeated wrapping periods with tick/done reporting
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int REP_W = REP_W_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] term,
    input  logic [REP_W-1:0] reps,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic [REP_W-1:0] rep_cnt,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [WIDTH-1:0] term_q;
    logic [REP_W-1:0] reps_q;
    logic             last;

    assign tick = (state == RUN) && (count == term_q);
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign last = tick && (reps_q != '0) && (rep_cnt == reps_q - 1'b1);

    // clearing in every non-RUN state covers start, stop, DONE and the illegal encoding
    up_count_clr #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .clr  (reset || state != RUN || tick || stop),
        .en   (state == RUN),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            term_q  <= '0;
            reps_q  <= '0;
            rep_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    term_q  <= term;
                    reps_q  <= reps;
                    rep_cnt <= '0;
                end
                RUN: if (stop) state <= IDLE;
                else if (tick) begin
                    rep_cnt <= rep_cnt + 1'b1;
                    if (last) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed and random stimulus checked against an elapsed-cycle reference model
module tb_count_seq_ctrl;
    logic       clk = 0;
    logic       reset = 1, start = 0, stop = 0;
    logic [3:0] term = 0, reps = 0;
    logic [3:0] count, rep_cnt;
    logic       tick, busy, done;
    int checks = 0, passes = 0;
    bit m_run = 0, m_done = 0;
    int m_e = 0, m_t = 0, m_r = 0, m_rep = 0;

    count_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .term(term), .reps(reps),
        .count(count), .tick(tick), .rep_cnt(rep_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    // model tracks elapsed RUN cycles; outputs follow from period arithmetic
    task automatic step();
        int ec, et, er, eb, ed;
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_done = 0; m_rep = 0; m_t = 0; m_r = 0;
        end else if (m_done) m_done = 0;
        else if (m_run) begin
            if (stop) begin
                m_run = 0;
                m_rep = (m_e / (m_t + 1)) % 16;
            end else begin
                m_e++;
                if (m_r != 0 && m_e == m_r * (m_t + 1)) begin
                    m_run = 0; m_done = 1; m_rep = m_r;
                end
            end
        end else if (start) begin
            m_run = 1; m_e = 0; m_t = int'(term); m_r = int'(reps);
        end
        #1;
        ec = m_run ? m_e % (m_t + 1) : 0;
        et = (m_run && ec == m_t) ? 1 : 0;
        er = m_run ? (m_e / (m_t + 1)) % 16 : m_rep;
        eb = (m_run || m_done) ? 1 : 0;
        ed = m_done ? 1 : 0;
        chk("count", 32'(count), 32'(ec));
        chk("tick", 32'(tick), 32'(et));
        chk("rep_cnt", 32'(rep_cnt), 32'(er));
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        steps(3);
        reset = 0;
        steps(5);
        term = 3; reps = 2; start = 1;
        step();
        start = 0; term = 4'hf; reps = 4'h7;
        steps(12);
        term = 0; reps = 3; start = 1;
        step();
        start = 0;
        steps(6);
        term = 1; reps = 0; start = 1;
        step();
        start = 0;
        steps(40);
        stop = 1;
        step();
        stop = 0;
        steps(3);
        term = 2; reps = 1; start = 1;
        step();
        start = 0;
        step();
        term = 9; start = 1;
        step();
        start = 0; stop = 1;
        step();
        stop = 0;
        steps(4);
        term = 5; reps = 2; start = 1;
        step();
        start = 0;
        steps(2);
        reset = 1;
        step();
        reset = 0; term = 2; reps = 2; start = 1;
        step();
        start = 0;
        steps(12);
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(3) == 0);
            stop  = ($urandom_range(15) == 0);
            reset = ($urandom_range(99) == 0);
            term  = 4'($urandom_range(15));
            reps  = 4'($urandom_range(3));
            step();
        end
        reset = 0; start = 0; stop = 0;
        steps(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
